// File: rtl/multiport_regfile.sv
// Multi-port register file with per-register busy (scoreboard) bits for WAW stall detection.
// Build option: define MULTIPORT_REGFILE_BYPASS_EN to forward same-cycle write data to readers.
module multiport_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_ok,
  output logic [CW-1:0]            busy_cnt
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CW-1:0]     busy_cnt_q, busy_cnt_d;

  // Writes apply in port order so the higher-index port wins a same-address collision.
  // The reservation is applied last: it keeps the busy bit set over a same-cycle write.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
        mem_d[wr_addr[w*AW +: AW]]  = wr_data[w*DATA_W +: DATA_W];
        busy_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_cnt_d = '0;
    for (int j = 0; j < DEPTH; j++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[j]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rdat;
    logic              rb;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      rdat = mem_q[ra];
      rb   = busy_q[ra];
      if (ra == '0) begin
        rdat = '0;
        rb   = 1'b0;
      end
`ifdef MULTIPORT_REGFILE_BYPASS_EN
      else begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
            rdat = wr_data[w*DATA_W +: DATA_W];
            rb   = 1'b0;
          end
        end
      end
`endif
      // Gate forwarded data too, so reads are zero for the whole reset window.
      if (!reset) begin
        rdat = '0;
        rb   = 1'b0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = rdat;
    assign rd_busy[i]                  = rb;
  end

  // Judged on pre-edge busy bits: a same-cycle write does not release the stall.
  assign rsv_ok   = reset && rsv_en && ((rsv_addr == '0) || !busy_q[rsv_addr]);
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against an array-based reference model.
module tb_multiport_regfile;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ok;
  logic [AW:0]       busy_cnt;

  multiport_regfile #(
    .DATA_W(DW),
    .DEPTH (DEPTH),
    .NUM_RD(NRD),
    .NUM_WR(NWR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .rsv_ok  (rsv_ok),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

`ifdef MULTIPORT_REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit fwd_hit(input logic [AW-1:0] a, output logic [DW-1:0] v);
    bit hit = 1'b0;
    v = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) begin
        hit = 1'b1;
        v   = wr_data[w*DW +: DW];
      end
    end
    return hit;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int i);
    logic [AW-1:0] a = rd_addr[i*AW +: AW];
    logic [DW-1:0] v;
    if (!reset || a == '0) return '0;
    if (Bypass && fwd_hit(a, v)) return v;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int i);
    logic [AW-1:0] a = rd_addr[i*AW +: AW];
    logic [DW-1:0] v;
    if (!reset || a == '0) return 1'b0;
    if (Bypass && fwd_hit(a, v)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_rsv_ok();
    return reset && rsv_en && (rsv_addr == '0 || !m_busy[rsv_addr]);
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int k = 0; k < DEPTH; k++) c += int'(m_busy[k]);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end
  endtask

  // State transition at a clock edge, from the inputs held over the finished cycle.
  task automatic model_update();
    logic [AW-1:0] a;
    for (int w = 0; w < NWR; w++) begin
      a = wr_addr[w*AW +: AW];
      if (wr_en[w] && a != '0) begin
        m_mem[a]  = wr_data[w*DW +: DW];
        m_busy[a] = 1'b0;
      end
    end
    if (rsv_en && rsv_addr != '0) m_busy[rsv_addr] = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        check($sformatf("rd_data%0d", i), 64'(rd_data[i*DW +: DW]), 64'(exp_rd(i)));
        check($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(exp_busy(i)));
      end
      check("rsv_ok", 64'(rsv_ok), 64'(exp_rsv_ok()));
      check("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
    end
  end

  task automatic idle();
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*AW +: AW]  = a;
    wr_data[p*DW +: DW]  = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask

  initial begin
    // Reset held with active-looking inputs: everything must read inactive.
    idle();
    rsv(5'd3);
    rd_addr = {5'd7, 5'd5};
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd5};
    wr_data = {32'h1, 32'h2};
    model_reset();
    #2;
    check("rst_rsv_ok", 64'(rsv_ok), 64'(0));
    check("rst_busy_cnt", 64'(busy_cnt), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_rd_busy", 64'(rd_busy), 64'(0));
    #6;
    idle();
    reset  = 1'b1;
    chk_en = 1'b1;

    wr(0, 5'd5, 32'hDEADBEEF);
    step();
    idle();
    rd_addr[0 +: AW] = 5'd5;
    #3 check("rd_addr5", 64'(rd_data[0 +: DW]), 64'hDEADBEEF);
    wr(0, 5'd0, 32'h1234);
    rd_addr[0 +: AW] = 5'd0;
    step();
    idle();
    #3 check("rd_addr0", 64'(rd_data[0 +: DW]), 64'h0);

    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    step();
    idle();
    rd_addr[0 +: AW] = 5'd7;
    #3 check("wr_collision", 64'(rd_data[0 +: DW]), 64'h22);

    rsv(5'd3);
    #3 check("rsv3_ok", 64'(rsv_ok), 64'(1));
    step();
    idle();
    rd_addr[AW +: AW] = 5'd3;
    #3 check("rsv3_cnt", 64'(busy_cnt), 64'(1));
    check("rsv3_rd_busy", 64'(rd_busy[1]), 64'(1));
    rsv(5'd3);
    #1 check("rsv3_again_ok", 64'(rsv_ok), 64'(0));
    step();
    idle();
    #3 check("rsv3_again_cnt", 64'(busy_cnt), 64'(1));
    wr(0, 5'd3, 32'h33);
    step();
    idle();
    #3 check("wr3_cnt", 64'(busy_cnt), 64'(0));

    rsv(5'd9);
    step();
    idle();
    rsv(5'd9);
    wr(1, 5'd9, 32'h55);
    #3 check("rsv9_busy_ok", 64'(rsv_ok), 64'(0));
    step();
    idle();
    rd_addr[0 +: AW] = 5'd9;
    #3 check("rd9", 64'(rd_data[0 +: DW]), 64'h55);
    check("rd9_busy", 64'(rd_busy[0]), 64'(1));
    check("rd9_cnt", 64'(busy_cnt), 64'(1));
    wr(0, 5'd9, 32'h56);
    step();
    idle();
    #3 check("free9_cnt", 64'(busy_cnt), 64'(0));
    rsv(5'd9);
    wr(0, 5'd9, 32'h57);
    #3 check("rsv9_free_ok", 64'(rsv_ok), 64'(1));
    step();
    idle();
    rd_addr[0 +: AW] = 5'd9;
    #3 check("rsvwr9_busy", 64'(rd_busy[0]), 64'(1));
    check("rsvwr9_cnt", 64'(busy_cnt), 64'(1));
    check("rsvwr9_data", 64'(rd_data[0 +: DW]), 64'h57);

    idle();
    wr(0, 5'd4, 32'hA5A5A5A5);
    rd_addr[AW +: AW] = 5'd4;
    #3 check("bypass_rd4", 64'(rd_data[AW > 0 ? DW : 0 +: DW]),
             Bypass ? 64'hA5A5A5A5 : 64'h0);
    step();
    idle();
    rd_addr[AW +: AW] = 5'd4;
    #3 check("rd4_after", 64'(rd_data[DW +: DW]), 64'hA5A5A5A5);

    rsv(5'd10);
    step();
    rsv(5'd11);
    step();
    rsv(5'd12);
    step();
    idle();
    rd_addr = {5'd7, 5'd5};
    #1 check("pre_rst_cnt", 64'(busy_cnt), 64'(4));
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_cnt", 64'(busy_cnt), 64'(0));
    check("mid_rst_rd0", 64'(rd_data[0 +: DW]), 64'h0);
    check("mid_rst_rd1", 64'(rd_data[DW +: DW]), 64'h0);
    #1 reset = 1'b1;
    step();

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NRD; i++)
        rd_addr[i*AW +: AW] = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7)
                                                            : $urandom_range(0, 31));
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]            = ($urandom_range(0, 2) == 0);
        wr_addr[w*AW +: AW] = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7)
                                                            : $urandom_range(0, 31));
        wr_data[w*DW +: DW] = $urandom;
      end
      rsv_en   = ($urandom_range(0, 1) != 0);
      rsv_addr = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
      if ($urandom_range(0, 149) == 0) begin
        #1 reset = 1'b0;
        model_reset();
        #1 reset = 1'b1;
      end
      step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
